// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to end a multiply once no multiplier bits remain set.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, opb_q, opb_d;
  logic [WIDTH-1:0]   mpl_q, mpl_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               isdiv_q, isdiv_d, dz_q, dz_d, sgn_q, sgn_d, sgna_q, sgna_d;
  logic               done_q, done_d;

  logic               sop, a_neg, b_neg, mul_last, div_last, ge;
  logic [WIDTH-1:0]   mag_a, mag_b, dif, q_fix, r_fix;
  logic [WIDTH:0]     rem_sh;
  logic [2*WIDTH-1:0] mul_acc, div_acc, p_fix;

  assign sop   = (op_i == 3'd0) || (op_i == 3'd2);
  assign a_neg = sop & src_a_i[WIDTH-1];
  assign b_neg = sop & src_b_i[WIDTH-1];
  assign mag_a = a_neg ? -src_a_i : src_a_i;
  assign mag_b = b_neg ? -src_b_i : src_b_i;

  // Multiply: multiplicand walks left, multiplier walks right.
  assign mul_acc = acc_q + (mpl_q[0] ? opb_q : '0);
`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = (mpl_q >> 1) == '0;
`else
  assign mul_last = cnt_q == CW'(WIDTH - 1);
`endif
  assign div_last = cnt_q == CW'(WIDTH - 1);

  // Restoring divide: acc = {remainder, dividend/quotient}.
  assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign ge      = rem_sh >= {1'b0, opb_q[WIDTH-1:0]};
  assign dif     = rem_sh[WIDTH-1:0] - opb_q[WIDTH-1:0];
  assign div_acc = ge ? {dif, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};

  assign p_fix = sgn_q ? -acc_q : acc_q;
  assign q_fix = sgn_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign r_fix = sgna_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q; acc_d = acc_q; opb_d = opb_q; mpl_d = mpl_q; cnt_d = cnt_q;
    isdiv_d = isdiv_q; dz_d = dz_q; sgn_d = sgn_q; sgna_d = sgna_q;
    hi_d = hi_q; lo_d = lo_q; done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start_i && !abort_i) begin
        if (op_i < 3'd4) begin
          state_d = op_i[1] ? S_DIV : S_MUL;
          isdiv_d = op_i[1];
          acc_d   = op_i[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
          opb_d   = {{WIDTH{1'b0}}, op_i[1] ? mag_b : mag_a};
          mpl_d   = mag_b;
          cnt_d   = '0;
          dz_d    = op_i[1] && (src_b_i == '0);
          sgn_d   = a_neg ^ b_neg;
          sgna_d  = a_neg;
        end else if (op_i == 3'd4) hi_d = src_a_i;
        else if (op_i == 3'd5)     lo_d = src_a_i;
      end
      S_MUL: begin
        acc_d = mul_acc;
        opb_d = opb_q << 1;
        mpl_d = mpl_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (mul_last) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = div_acc;
        cnt_d = cnt_q + CW'(1);
        if (div_last) state_d = S_FIX;
      end
      default: begin
        if (isdiv_q) begin
          hi_d = r_fix;
          lo_d = dz_q ? '1 : q_fix;
        end else begin
          hi_d = p_fix[2*WIDTH-1:WIDTH];
          lo_d = p_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    // A flush cancels any in-flight op, including its commit.
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE; hi_d = hi_q; lo_d = lo_q; done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE; acc_q <= '0; opb_q <= '0; mpl_q <= '0; cnt_q <= '0;
      isdiv_q <= 1'b0; dz_q <= 1'b0; sgn_q <= 1'b0; sgna_q <= 1'b0;
      hi_q <= '0; lo_q <= '0; done_q <= 1'b0;
    end else begin
      state_q <= state_d; acc_q <= acc_d; opb_q <= opb_d; mpl_q <= mpl_d; cnt_q <= cnt_d;
      isdiv_q <= isdiv_d; dz_q <= dz_d; sgn_q <= sgn_d; sgna_q <= sgna_d;
      hi_q <= hi_d; lo_q <= lo_d; done_q <= done_d;
    end
  end

  assign busy_o = state_q != S_IDLE;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule
